key_debounce_trig: RTL and testbench



---
 rtl/key_debounce_trig_pkg.sv | 28 ++
 rtl/key_debounce_trig_if.sv | 20 ++
 rtl/sync_2ff.sv | 34 +++
 rtl/key_debounce_trig.sv | 147 ++++++++++++++
 tb/tb_key_debounce_trig.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : key_pkg (package)
//  Purpose : Shared types and constants for the key debounce/trigger block.
//            - key_state_t : debounce FSM state, 2-bit encoding
//            - KEY_PRESSED : raw key polarity (button pulls the line low)
//            - max3()      : helper for counter-width sanity checking
//  Revision: 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    localparam logic KEY_PRESSED = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_debounce_trig_if.sv
`default_nettype none
// ============================================================================
//  Module  : key_debounce_trig_if (interface)
//  Purpose : Bundles the key input and the two debounced outputs.
//  Signals : key_in    - raw button, active-low, asynchronous
//            en_pulse  - one-clock trigger per accepted press
//            key_level - debounced level, 1 = pressed
//  Modports: master - drives key_in, observes the outputs (button side / bench)
//            slave  - the debounce block itself
//  Revision: 1.0 - initial release
// ============================================================================
interface key_debounce_trig_if;
    logic key_in;
    logic en_pulse;
    logic key_level;

    modport master (output key_in, input en_pulse, input key_level);
    modport slave  (input key_in, output en_pulse, output key_level);
endinterface : key_debounce_trig_if
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module  : sync_2ff
//  Purpose : 1-bit two-flop synchroniser for an asynchronous input.
//  Ports   : clk - destination clock
//            rst - asynchronous active-high reset (both flops -> RST_VAL)
//            d   - asynchronous input
//            q   - synchronised output (two clocks of latency)
//  Params  : RST_VAL - value loaded into both flops on reset
//  Revision: 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce_trig.sv
`default_nettype none
// ============================================================================
//  Module  : key_debounce_trig
//  Purpose : Synchronises and debounces a raw active-low push-button and
//            emits a single-clock trigger pulse per confirmed press.
//  Ports   : clk  - system clock
//            rst  - asynchronous active-high reset
//            bus  - key_debounce_trig_if.slave
//                   key_in (in), en_pulse (out), key_level (out)
//  Params  : DEBOUNCE_CYC - stable clocks needed to accept press/release
//            CNT_W        - width of debounce and repeat counters
//            REPEAT_DLY   - clocks in DOWN before first auto-repeat pulse
//            REPEAT_PER   - clocks between subsequent auto-repeat pulses
//  Config  : define KEY_REPEAT_EN to enable auto-repeat while held.
//  Revision: 1.0 - initial release
// ============================================================================
module key_debounce_trig
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 20,
    parameter int CNT_W        = 16,
    parameter int REPEAT_DLY   = 100,
    parameter int REPEAT_PER   = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    key_debounce_trig_if.slave   bus
);

    localparam int              CNT_NEED = max3(DEBOUNCE_CYC, REPEAT_DLY, REPEAT_PER);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    // Elaboration-time guard: counters must be able to hold every terminal count.
    if (((longint'(1) << CNT_W) <= longint'(CNT_NEED)) || (DEBOUNCE_CYC < 2)) begin : g_param_check
        $error("key_debounce_trig: CNT_W too small or DEBOUNCE_CYC < 2");
    end

    logic             key_s;
    key_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             pulse_q;
    logic             level_q;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_DLY_LAST = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] REP_PER_LAST = CNT_W'(REPEAT_PER - 1);
    logic [CNT_W-1:0] rep_cnt;
    logic             rep_first;  // still waiting for the first (longer) repeat interval
`endif

    // Released level (1) on reset so that a reset never looks like a press edge.
    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.key_in),
        .q   (key_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse_q   <= 1'b0;
            level_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b1;
`endif
        end else begin
            pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
`ifdef KEY_REPEAT_EN
                    rep_cnt   <= '0;
                    rep_first <= 1'b1;
`endif
                    if (key_s == KEY_PRESSED) begin
                        state <= PRESS_WAIT;
                    end
                end

                PRESS_WAIT: begin
                    if (key_s != KEY_PRESSED) begin
                        state <= IDLE;        // bounce rejected
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= DOWN;
                        cnt     <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
`ifdef KEY_REPEAT_EN
                        rep_cnt   <= '0;
                        rep_first <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DOWN: begin
                    if (key_s != KEY_PRESSED) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rep_cnt == (rep_first ? REP_DLY_LAST : REP_PER_LAST)) begin
                        pulse_q   <= 1'b1;
                        rep_cnt   <= '0;
                        rep_first <= 1'b0;
                    end else begin
                        rep_cnt <= rep_cnt + CNT_W'(1);
                    end
`endif
                end

                RELEASE_WAIT: begin
                    // Repeat counter is intentionally left untouched here so a
                    // release bounce resumes the repeat cadence where it left off.
                    if (key_s == KEY_PRESSED) begin
                        state <= DOWN;        // release bounce, no new pulse
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en_pulse  = pulse_q;
    assign bus.key_level = level_q;

endmodule : key_debounce_trig
`default_nettype wire

// File: tb/tb_key_debounce_trig.sv
`default_nettype none
// ============================================================================
//  Module  : tb_key_debounce_trig
//  Purpose : Directed self-checking bench for key_debounce_trig
//            (DEBOUNCE_CYC=20, REPEAT_DLY=100, REPEAT_PER=50).
//            Inputs change 1 time unit after a rising edge; outputs are
//            sampled at the same point. A key_in change made after edge e
//            is first seen at edge k=e+1, so the press pulse is visible
//            after the 23rd tick following the change.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_key_debounce_trig;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks     = 0;
    int failures   = 0;
    int pulse_cnt  = 0;
    int consec_err = 0;
    logic prev_pulse = 1'b0;

    key_debounce_trig_if bus ();

    key_debounce_trig #(
        .DEBOUNCE_CYC (20),
        .CNT_W        (16),
        .REPEAT_DLY   (100),
        .REPEAT_PER   (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping: total pulses and any back-to-back pulses.
    always @(negedge clk) begin
        if (bus.en_pulse === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_pulse) consec_err = consec_err + 1;
        end
        prev_pulse = (bus.en_pulse === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tick n times, counting cycles where key_level differs from exp_lvl.
    task automatic hold_level(input int n, input logic exp_lvl, output int bad);
        bad = 0;
        repeat (n) begin
            tick(1);
            if (bus.key_level !== exp_lvl) bad++;
        end
    endtask

    // Call right after driving key_in low on a clean line: checks exact latency.
    task automatic expect_press(input string tag);
        tick(22);
        chk({tag, "_no_early_pulse"}, bus.en_pulse, 1'b0);
        chk({tag, "_level_before"},   bus.key_level, 1'b0);
        tick(1);
        chk({tag, "_pulse"},          bus.en_pulse, 1'b1);
        chk({tag, "_level_rise"},     bus.key_level, 1'b1);
        tick(1);
        chk({tag, "_pulse_one_clk"},  bus.en_pulse, 1'b0);
    endtask

    initial begin
        int p0;
        int b1, b2, b3;
        int bad;
        logic exp_p;

        bus.key_in = 1'b1;

        // ---------------- reset state ----------------
        tick(3);
        chk("reset_en_pulse",  bus.en_pulse,  1'b0);
        chk("reset_key_level", bus.key_level, 1'b0);
        rst = 1'b0;
        tick(5);

        // ---------------- clean press, 200 clocks ----------------
        p0 = pulse_cnt;
        bus.key_in = 1'b0;
        expect_press("clean");
        tick(176);
        chk("clean_single_pulse", pulse_cnt - p0, 1);
        chk("clean_level_held",   bus.key_level, 1'b1);
        bus.key_in = 1'b1;
        tick(22);
        chk("clean_level_before_fall", bus.key_level, 1'b1);
        tick(1);
        chk("clean_level_fall", bus.key_level, 1'b0);
        tick(10);

        // ---------------- press bounce ----------------
        p0 = pulse_cnt;
        for (int i = 0; i < 4; i++) begin
            bus.key_in = 1'b0;
            tick(5);
            bus.key_in = 1'b1;
            tick(3);
        end
        chk("bounce_no_pulse_during", pulse_cnt - p0, 0);
        bus.key_in = 1'b0;
        expect_press("bounce");
        chk("bounce_single_pulse", pulse_cnt - p0, 1);
        bus.key_in = 1'b1;
        tick(30);
        chk("bounce_released", bus.key_level, 1'b0);

        // ---------------- short glitch, 19 clocks ----------------
        p0 = pulse_cnt;
        bus.key_in = 1'b0;
        hold_level(19, 1'b0, b1);
        bus.key_in = 1'b1;
        hold_level(40, 1'b0, b2);
        chk("glitch_level_stays_0", b1 + b2, 0);
        chk("glitch_no_pulse", pulse_cnt - p0, 0);

        // ---------------- release bounce ----------------
        p0 = pulse_cnt;
        bus.key_in = 1'b0;
        expect_press("relb");
        tick(10);
        bus.key_in = 1'b1;
        hold_level(10, 1'b1, b1);
        bus.key_in = 1'b0;
        hold_level(10, 1'b1, b2);
        bus.key_in = 1'b1;
        hold_level(22, 1'b1, b3);
        chk("relb_level_held_through_bounce", b1 + b2 + b3, 0);
        tick(1);
        chk("relb_level_fall", bus.key_level, 1'b0);
        chk("relb_single_pulse", pulse_cnt - p0, 1);
        tick(10);

        // ---------------- reset mid-debounce ----------------
        p0 = pulse_cnt;
        bus.key_in = 1'b0;
        tick(13);                      // PRESS_WAIT with cnt == 10
        rst = 1'b1;
        #1;
        chk("midrst_en_pulse",  bus.en_pulse,  1'b0);
        chk("midrst_key_level", bus.key_level, 1'b0);
        tick(2);
        rst = 1'b0;
        expect_press("midrst_after");
        chk("midrst_single_pulse", pulse_cnt - p0, 1);

        // reset while DOWN: level must drop asynchronously
        rst = 1'b1;
        #1;
        chk("downrst_level_async", bus.key_level, 1'b0);
        tick(1);
        rst = 1'b0;
        bus.key_in = 1'b1;
        tick(40);
        chk("downrst_no_extra_pulse", pulse_cnt - p0, 1);

        // ---------------- hold 300 clocks (repeat pattern) ----------------
        p0 = pulse_cnt;
        bad = 0;
        bus.key_in = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick(1);
`ifdef KEY_REPEAT_EN
            exp_p = (i == 23) || (i == 123) || (i == 173) || (i == 223) || (i == 273);
`else
            exp_p = (i == 23);
`endif
            if (bus.en_pulse !== exp_p) bad++;
        end
        chk("hold300_pulse_pattern", bad, 0);
`ifdef KEY_REPEAT_EN
        chk("hold300_pulse_count", pulse_cnt - p0, 5);
`else
        chk("hold300_pulse_count", pulse_cnt - p0, 1);
`endif
        bus.key_in = 1'b1;
        tick(40);
        chk("hold300_released", bus.key_level, 1'b0);

        chk("no_consecutive_pulses", consec_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_key_debounce_trig
`default_nettype wire
